spi_reg_bridge: RTL
===================

Name: spi_reg_bridge

Overview:
- Byte-level command decoder directly downstream of the SPI slave byte engine.
- Consumes received bytes and frame boundaries, and implements a simple addressed register protocol with auto-increment.
- Supplies the byte that the slave shifts out next on MISO.
- Exposes a small RW register bank and write strobes to the FPGA user logic, plus read-only status and ID locations.

Parameters:
- NUM_REGS, 16, number of RW 8-bit registers at addresses 0..NUM_REGS-1 (1..126).
- RESET_VAL, 8'h00, reset value of every RW register.
- DEV_ID, 8'hC5, value returned when address 7'h7F is read.
- IDLE_TX, 8'hA5, byte presented on tx_data outside a read burst.

Ports:
- clk  in  1  system clock, same domain as the SPI slave.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse, SSEL asserted.
- frame_end  in  1  one-cycle pulse, SSEL deasserted.
- rx_valid  in  1  one-cycle pulse, rx_data holds a complete received byte.
- rx_data  in  8  received byte, MSB-first assembled.
- tx_data  out  8  next byte for the slave to shift out; sampled by the slave at each byte boundary.
- status_in  in  8  user status byte, readable at 7'h7E.
- regs_out  out  8*NUM_REGS  flat RW register bank; reg i is bits [8i+7:8i].
- wr_stb  out  1  one-cycle pulse on every accepted RW-register write.
- wr_addr  out  7  address of that write.
- wr_data  out  8  data of that write.
- err_cnt  out  8  count of protocol errors, saturating at 8'hFF.

Behaviour:
- Reset (async, rst_n=0) sets the following:
  - state IDLE
  - all registers RESET_VAL
  - tx_data IDLE_TX
  - wr_stb 0, wr_addr 0, wr_data 0
  - err_cnt 0
  - internal address pointer 0
- Reset mid-frame abandons the frame; no partial write is committed.
- States: IDLE, CMD, WRITE, READ. Encoding lives in the package.
- Transitions:
  - IDLE: frame_start -> CMD. rx_valid in IDLE is ignored and increments err_cnt.
  - CMD: on rx_valid, ptr <= rx_data[6:0]. rx_data[7]=1 -> READ, else WRITE.
  - On entering READ, tx_data <= rd(ptr), then ptr <= ptr+1.
  - WRITE: on each rx_valid, if ptr < NUM_REGS then reg[ptr] <= rx_data and wr_stb=1 for one cycle with wr_addr=ptr, wr_data=rx_data. Then ptr <= ptr+1.
  - WRITE to 7'h7E, 7'h7F or any ptr >= NUM_REGS: discarded, no wr_stb, err_cnt unchanged.
  - READ: each rx_valid (dummy byte, content ignored) loads tx_data <= rd(ptr), then ptr <= ptr+1.
  - Any state: frame_end -> IDLE, tx_data <= IDLE_TX.
  - frame_end in CMD with no command byte received increments err_cnt.
- Read mux rd(a):
  - reg[a] if a < NUM_REGS
  - status_in if a == 7'h7E, sampled on the loading cycle
  - DEV_ID if a == 7'h7F
  - 8'h00 otherwise
- Pointer is 7 bits and wraps 7'h7F -> 7'h00.
- Latency:
  - tx_data, registers and wr_stb all update on the clk edge after the rx_valid cycle.
  - The slave samples tx_data at least one full SCK period later; no further handshake is needed.
- Protocol timing: the first MISO byte of every frame is IDLE_TX. Read data for address A appears on MISO in the second byte of the frame; byte k+1 carries A+k-1.
- Simultaneous events:
  - rx_valid with frame_end: process the byte first (write commits / tx loads), then go IDLE with tx_data=IDLE_TX.
  - frame_start in a non-IDLE state: restart at CMD, no err.
  - frame_start with frame_end: frame_end wins, state IDLE.
- err_cnt saturates at 8'hFF.
- wr_stb never asserts outside WRITE.

Decomposition:
- Package spi_reg_pkg holds:
  - state enum
  - ADDR_STATUS=7'h7E, ADDR_ID=7'h7F
  - CMD_RD_BIT=7
  - pointer width 7
- One sub-module, spi_reg_file, holds:
  - NUM_REGS x 8 storage with write port (we, addr, data) and RESET_VAL reset
  - combinational read mux including status/ID/zero cases
  - flat regs_out
- The FSM, pointer and err_cnt stay in spi_reg_bridge.

Test Plan:
- Write burst: frame_start, bytes 0x02,0x11,0x22,0x33, frame_end -> regs 2,3,4 = 11,22,33; three wr_stb pulses with addr 2,3,4; final tx_data=A5.
- Read burst: preload regs 5=0x5A, 6=0x6B; frame with 0x85 then two dummies -> tx_data sequence A5,5A,6B; after frame_end, A5.
- Special addresses: read from 0x7E with status_in=0x3C -> 3C, C5 (ID), then 00 (wrap to addr 0 if RESET_VAL=0; verify pointer wrap by reading reg0 after setting it to 0x77 -> 77).
- Out-of-range write to 0x10 with NUM_REGS=16 -> no wr_stb, regs unchanged, err_cnt 0.
- Errors and races:
  - rx_valid with no frame -> err_cnt=1.
  - Empty frame -> err_cnt=2.
  - rx_valid together with frame_end on the last write byte -> write committed, state IDLE.
- Assert rst_n low in the middle of a write burst -> all regs RESET_VAL, tx_data A5, no wr_stb; the next frame works normally.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register bridge: FSM encoding, special addresses,
// command-byte layout and pointer width.
package spi_reg_pkg;

    localparam int PTR_W      = 7;
    localparam int CMD_RD_BIT = 7;

    localparam logic [PTR_W-1:0] ADDR_STATUS = 7'h7E;
    localparam logic [PTR_W-1:0] ADDR_ID     = 7'h7F;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_CMD   = 2'd1;
    localparam state_t ST_WRITE = 2'd2;
    localparam state_t ST_READ  = 2'd3;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Byte-engine side of the bridge (frame/byte events in, next MISO byte out)
// plus the write-notification port towards the user logic.
interface spi_reg_bridge_if;

    logic       frame_start;
    logic       frame_end;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       wr_stb;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;

    modport master (
        output frame_start, frame_end, rx_valid, rx_data,
        input  tx_data, wr_stb, wr_addr, wr_data
    );

    modport slave (
        input  frame_start, frame_end, rx_valid, rx_data,
        output tx_data, wr_stb, wr_addr, wr_data
    );

endinterface

// File: rtl/spi_reg_file.sv
// RW register storage with a single write port and a combinational read mux
// that also decodes the status, ID and unmapped addresses.
module spi_reg_file
    import spi_reg_pkg::*;
#(
    parameter int         NUM_REGS  = 16,
    parameter logic [7:0] RESET_VAL = 8'h00,
    parameter logic [7:0] DEV_ID    = 8'hC5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [PTR_W-1:0]      wr_addr,
    input  logic [7:0]            wr_data,
    input  logic [PTR_W-1:0]      rd_addr,
    input  logic [7:0]            status_in,
    output logic [7:0]            rd_data,
    output logic [8*NUM_REGS-1:0] regs_out
);

    logic [7:0] mem [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= RESET_VAL;
        end else if (we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_addr == PTR_W'(i)) mem[i] <= wr_data;
            end
        end
    end

    // Status and ID sit above the RW range, so they are decoded first.
    always_comb begin
        rd_data = 8'h00;
        if (rd_addr == ADDR_STATUS) begin
            rd_data = status_in;
        end else if (rd_addr == ADDR_ID) begin
            rd_data = DEV_ID;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rd_addr == PTR_W'(i)) rd_data = mem[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_out[8*g +: 8] = mem[g];
    end

endmodule

// File: rtl/spi_reg_bridge.sv
// Command decoder behind the SPI slave byte engine: addressed register access
// with auto-increment, MISO byte preparation and protocol error counting.
module spi_reg_bridge
    import spi_reg_pkg::*;
#(
    parameter int         NUM_REGS  = 16,
    parameter logic [7:0] RESET_VAL = 8'h00,
    parameter logic [7:0] DEV_ID    = 8'hC5,
    parameter logic [7:0] IDLE_TX   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_reg_bridge_if.slave       bus,
    input  logic [7:0]            status_in,
    output logic [8*NUM_REGS-1:0] regs_out,
    output logic [7:0]            err_cnt
);

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] rd_addr;
    logic [7:0]       rd_data;
    logic             in_range;
    logic             we;
    logic             err_inc;

    // The command byte itself addresses the first read, before ptr is loaded.
    assign rd_addr  = (state == ST_CMD) ? bus.rx_data[PTR_W-1:0] : ptr;
    assign in_range = int'(ptr) < NUM_REGS;
    assign we       = (state == ST_WRITE) && bus.rx_valid && in_range;
    assign err_inc  = ((state == ST_IDLE) && bus.rx_valid) ||
                      ((state == ST_CMD) && bus.frame_end && !bus.rx_valid);

    spi_reg_file #(
        .NUM_REGS  (NUM_REGS),
        .RESET_VAL (RESET_VAL),
        .DEV_ID    (DEV_ID)
    ) u_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .wr_addr   (ptr),
        .wr_data   (bus.rx_data),
        .rd_addr   (rd_addr),
        .status_in (status_in),
        .rd_data   (rd_data),
        .regs_out  (regs_out)
    );

    // A byte arriving with a frame boundary is handled first; the boundary
    // then overrides state and tx_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            bus.tx_data <= IDLE_TX;
            bus.wr_stb  <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            err_cnt     <= '0;
        end else begin
            bus.wr_stb <= 1'b0;
            if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;

            if (bus.rx_valid) begin
                case (state)
                    ST_CMD: begin
                        if (bus.rx_data[CMD_RD_BIT]) begin
                            state       <= ST_READ;
                            bus.tx_data <= rd_data;
                            ptr         <= bus.rx_data[PTR_W-1:0] + 1'b1;
                        end else begin
                            state <= ST_WRITE;
                            ptr   <= bus.rx_data[PTR_W-1:0];
                        end
                    end
                    ST_WRITE: begin
                        if (in_range) begin
                            bus.wr_stb  <= 1'b1;
                            bus.wr_addr <= ptr;
                            bus.wr_data <= bus.rx_data;
                        end
                        ptr <= ptr + 1'b1;
                    end
                    ST_READ: begin
                        bus.tx_data <= rd_data;
                        ptr         <= ptr + 1'b1;
                    end
                    default: ;
                endcase
            end

            if (bus.frame_end) begin
                state       <= ST_IDLE;
                bus.tx_data <= IDLE_TX;
            end else if (bus.frame_start) begin
                state       <= ST_CMD;
                bus.tx_data <= IDLE_TX;
            end
        end
    end

endmodule
